// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and default filler word for the loadable instruction memory
package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} imem_state_t;
  localparam logic [31:0] NOP_DEFAULT = 32'h0;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port DEPTH x DATA_W storage, synchronous write and enabled synchronous read
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with registered fetch, stall hold and
// fault flagging for PCs outside the loaded program or misaligned byte addresses.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_en,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  input  logic                       stall,
  output logic [DATA_W-1:0]          inst,
  output logic                       inst_valid,
  output logic                       addr_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  imem_state_t       state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, prog_len_q, prog_len_d;
  logic              load_done_q, load_done_d, inst_valid_q, inst_valid_d;
  logic              fault_q, fault_d, sel_q, sel_d;
  logic [ADDR_W-1:0] idx;
  logic              hit, wr_en, fetch_ok;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  always_comb begin
    idx        = BYTE_ADDR ? (fetch_addr >> 2) : fetch_addr;
    // full-width compare so large PCs never alias into the program
    hit        = !(BYTE_ADDR && fetch_addr[1:0] != 2'b00) &&
                 ({{PW{1'b0}}, idx} < {{ADDR_W{1'b0}}, prog_len_q});
    load_ready = (state_q == LOAD) && (wr_ptr_q < PW'(DEPTH));
    wr_en      = load_ready && load_valid;
    fetch_ok   = (state_q != LOAD) && !load_en && fetch_req && !stall;
    ram_addr   = wr_en ? wr_ptr_q[AW-1:0] : idx[AW-1:0];
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    load_done_d  = 1'b0;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    sel_d        = sel_q;
    if (state_q == LOAD) begin
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      if (!load_en) begin
        state_d     = RUN;
        load_done_d = 1'b1;
        prog_len_d  = wr_ptr_d;
      end
    end else if (load_en) begin
      state_d      = LOAD;
      wr_ptr_d     = '0;
      prog_len_d   = '0;
      inst_valid_d = 1'b0;
    end else if (!stall) begin
      inst_valid_d = fetch_req;
      fault_d      = fetch_req ? !hit : fault_q;
      sel_d        = fetch_req ? hit : sel_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      load_done_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      load_done_q  <= load_done_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      sel_q        <= sel_d;
    end
  end
  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (fetch_ok),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );
  // the RAM read register holds across idle cycles; sel_q picks it or the filler word
  assign inst       = sel_q ? ram_rdata : NOP_WORD;
  assign inst_valid = inst_valid_q;
  assign addr_fault = fault_q;
  assign load_done  = load_done_q;
  assign prog_len   = prog_len_q;
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: randomized scoreboard bench; a word-addressed DEPTH=8 instance and a
// byte-addressed DEPTH=16 instance share stimulus and are checked against a program-list model.
module tb_imem_loadable;
  logic        clk = 0, rst_n = 0;
  logic        load_en = 0, load_valid = 0, fetch_req = 0, stall = 0;
  logic [31:0] load_data = 0, fetch_addr = 0;
  logic [31:0] inst_o [2];
  logic        iv_o [2], flt_o [2], rdy_o [2], done_o [2];
  logic [3:0]  plen_o0;
  logic [4:0]  plen_o1;
  int          n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] i0; logic f0; logic [31:0] i1; logic f1; } exp_t;
  exp_t        exp_q [$];
  logic [31:0] mem0 [8];
  logic [31:0] mem1 [16];
  int          cnt0, cnt1, plen0, plen1, st;
  logic        stall_e, lden_e;
  logic [31:0] prev_i [2];
  logic        prev_v [2], prev_f [2];

  always #5 clk = ~clk;

  imem_loadable #(.DEPTH(8), .BYTE_ADDR(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_o[0]), .load_done(done_o[0]), .prog_len(plen_o0), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .stall(stall), .inst(inst_o[0]), .inst_valid(iv_o[0]),
    .addr_fault(flt_o[0]));
  imem_loadable #(.DEPTH(16), .BYTE_ADDR(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_o[1]), .load_done(done_o[1]), .prog_len(plen_o1), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .stall(stall), .inst(inst_o[1]), .inst_valid(iv_o[1]),
    .addr_fault(flt_o[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: word i of the program is valid only below the loaded length
  function automatic exp_t predict(input logic [31:0] a);
    exp_t p;
    logic [31:0] w;
    logic ok;
    ok   = a < 32'(plen0);
    p.i0 = ok ? mem0[a[2:0]] : 32'h0;
    p.f0 = !ok;
    w    = a / 4;
    ok   = (a % 4 == 0) && w < 32'(plen1);
    p.i1 = ok ? mem1[w[3:0]] : 32'h0;
    p.f1 = !ok;
    return p;
  endfunction

  task automatic step();
    exp_t e;
    bit push = 0, done_e = 0;
    chk("load_ready0", rdy_o[0], st == 1 && cnt0 < 8);
    chk("load_ready1", rdy_o[1], st == 1 && cnt1 < 16);
    if (st == 1) begin
      if (load_valid && cnt0 < 8) begin mem0[cnt0] = load_data; cnt0++; end
      if (load_valid && cnt1 < 16) begin mem1[cnt1] = load_data; cnt1++; end
      if (!load_en) begin st = 2; plen0 = cnt0; plen1 = cnt1; done_e = 1; end
    end else if (load_en) begin
      st = 1; cnt0 = 0; cnt1 = 0; plen0 = 0; plen1 = 0;
    end else if (fetch_req && !stall) begin
      push = 1; e = predict(fetch_addr);
    end
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    chk("load_done0", done_o[0], done_e);
    chk("load_done1", done_o[1], done_e);
    chk("prog_len0", plen_o0, plen0);
    chk("prog_len1", plen_o1, plen1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rq, input logic stl);
    fetch_addr = a; fetch_req = rq; stall = stl;
    step();
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_inst", inst_o[k], 0);
      chk("rst_valid", iv_o[k], 0);
      chk("rst_fault", flt_o[k], 0);
      chk("rst_ready", rdy_o[k], 0);
      chk("rst_done", done_o[k], 0);
    end
    chk("rst_plen0", plen_o0, 0);
    chk("rst_plen1", plen_o1, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; load_en = 0; load_valid = 0; fetch_req = 0; stall = 0;
    #2;
    check_reset_outputs();
    st = 0; cnt0 = 0; cnt1 = 0; plen0 = 0; plen1 = 0;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic load(input int n, input bit rnd);
    int sent = 0;
    load_en = 1; load_valid = 0;
    fetch_req = rnd ? 1'($urandom % 2) : 1'b0;
    stall = rnd ? 1'($urandom % 2) : 1'b0;
    step();
    while (sent < n) begin
      load_valid = rnd ? 1'($urandom % 3 != 0) : 1'b1;
      load_data = $urandom;
      fetch_req = rnd ? 1'($urandom % 2) : 1'b0;
      if (load_valid) sent++;
      step();
    end
    load_valid = 0; load_en = 0; fetch_req = 0; stall = 0;
    step();
  endtask

  always @(posedge clk) begin
    stall_e <= stall;
    lden_e  <= load_en;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_e && !lden_e) begin
        for (int k = 0; k < 2; k++) begin
          chk("hold_inst", inst_o[k], prev_i[k]);
          chk("hold_valid", iv_o[k], prev_v[k]);
          chk("hold_fault", flt_o[k], prev_f[k]);
        end
      end else if (iv_o[0] || iv_o[1]) begin
        if (exp_q.size() == 0) chk("unexpected_valid", {iv_o[1], iv_o[0]}, 0);
        else begin
          e = exp_q.pop_front();
          chk("valid0", iv_o[0], 1);
          chk("valid1", iv_o[1], 1);
          chk("inst0", inst_o[0], e.i0);
          chk("fault0", flt_o[0], e.f0);
          chk("inst1", inst_o[1], e.i1);
          chk("fault1", flt_o[1], e.f1);
        end
      end
      if (exp_q.size() != 0) begin
        chk("missing_response", exp_q.size(), 0);
        exp_q.delete();
      end
    end
    for (int k = 0; k < 2; k++) begin
      prev_i[k] = inst_o[k]; prev_v[k] = iv_o[k]; prev_f[k] = flt_o[k];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    do_reset();
    fetch(0, 1, 0);
    fetch(0, 0, 0);
    load(4, 0);
    for (int i = 0; i < 5; i++) fetch(i, 1, 0);
    fetch(8, 1, 0);
    fetch(6, 1, 0);
    fetch(32'h8000_0000, 1, 0);
    fetch(0, 0, 0);
    fetch(0, 1, 0);
    fetch(1, 1, 0);
    for (int i = 0; i < 3; i++) fetch($urandom_range(0, 15), 1, 1);
    fetch(2, 1, 0);
    fetch(3, 0, 0);
    load(10, 0);
    for (int i = 0; i < 12; i++) fetch(i, 1, 0);
    for (int i = 0; i < 12; i++) fetch(i * 4, 1, 0);
    load_en = 1; load_valid = 0;
    step();
    for (int i = 0; i < 2; i++) begin load_valid = 1; load_data = $urandom; step(); end
    rst_n = 0;
    #1;
    check_reset_outputs();
    st = 0; cnt0 = 0; cnt1 = 0; plen0 = 0; plen1 = 0;
    load_en = 0; load_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    fetch(0, 0, 0);
    fetch(0, 1, 0);
    fetch(0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 100 < 3) load($urandom_range(0, 18), 1);
      else begin
        a = ($urandom % 8 == 0) ? (32'h8000_0000 | ($urandom % 16)) : $urandom_range(0, 63);
        fetch(a, 1'($urandom % 4 != 0), 1'($urandom % 5 == 0));
      end
    end
    fetch(0, 0, 0);
    fetch(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
